// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared constants for the bit-serial adder controller. Holds the
//               FSM state encoding, default operand width and counter width.
// Revision    : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

   // FSM state encoding
   typedef logic [1:0] state_t;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int SA_DEFAULT_WIDTH = 8;

   // Bit counter width; never narrower than one bit
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell shared by the serial adder.
// Revision    : 1.0  initial release
// ============================================================================
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder controller. Adds two WIDTH-bit operands LSB
//               first through one full_adder cell, one bit per cycle, with a
//               registered carry fed back between bits. Start/busy/done
//               handshake. Optional signed-overflow output is enabled by the
//               macro SERIAL_ADDER_OVF_EN.
// Revision    : 1.0  initial release
// ============================================================================
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] OP_A,
   input  logic [WIDTH-1:0] OP_B,
   input  logic             CIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             OVF
`endif
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   // Holds the result bits gathered so far, MSB-aligned; the newest bit is
   // prepended each cycle so a full WIDTH-bit word exists only on the last bit.
   logic [WIDTH-2:0]   sum_sr_q, sum_sr_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   logic               fa_sum;
   logic               fa_cout;
   logic [WIDTH-1:0]   sum_next;

   // The single shared bit cell
   full_adder u_bit_cell (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign sum_next = {fa_sum, sum_sr_q};

   // Next-state logic: FSM, operand shifters, carry loop and result capture
   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_SHIFT;
               a_sr_d  = OP_A;
               b_sr_d  = OP_B;
               carry_d = CIN;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            carry_d  = fa_cout;
            sum_sr_d = sum_next[WIDTH-1:1];
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               sum_d   = sum_next;
               cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q is the carry into the MSB on this last bit
               ovf_d   = carry_q ^ fa_cout;
`endif
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign BUSY = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   assign DONE = (state_q == ST_DONE);
   assign SUM  = sum_q;
   assign COUT = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign OVF  = ovf_q;
`endif

endmodule
`default_nettype wire
